// File: rtl/axi_lite_regbank.sv
// AXI4-Lite register bank with independent read and write paths.
// Registers flagged in RO_MASK are read-only: reads return hw_in, writes only pulse wr_pulse.
// Optional macro AXIL_REGBANK_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi_lite_regbank #(
    parameter int unsigned          ADDR_WIDTH = 12,
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    // Write address channel
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    // Write data channel
    input  logic                           WVALID,
    output logic                           WREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    // Write response channel
    output logic                           BVALID,
    input  logic                           BREADY,
    output logic [1:0]                     BRESP,
    // Read address channel
    input  logic                           ARVALID,
    output logic                           ARREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    // Read data channel
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    // Hardware side
    output logic [NUM_REGS*DATA_WIDTH-1:0] hw_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned ALSB       = (DATA_WIDTH == 64) ? 3 : 2;
    localparam int unsigned IDX_WIDTH  = ADDR_WIDTH - ALSB;
    // One extra bit so NUM_REGS == 2**IDX_WIDTH is representable.
    localparam logic [IDX_WIDTH:0] REG_COUNT = (IDX_WIDTH + 1)'(NUM_REGS);

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REGBANK_SLVERR_EN
    localparam logic [1:0] RESP_OOR  = 2'b10;
`else
    localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

    logic                   aw_held_q;
    logic [IDX_WIDTH-1:0]   aw_idx_q;
    logic                   w_held_q;
    logic [DATA_WIDTH-1:0]  w_data_q;
    logic [STRB_WIDTH-1:0]  w_strb_q;
    logic                   bvalid_q;
    logic [1:0]             bresp_q;
    logic [NUM_REGS-1:0]    wr_pulse_q;
    logic                   rvalid_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic [1:0]             rresp_q;
    logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];

    logic                   aw_hs;
    logic                   w_hs;
    logic                   ar_hs;
    logic                   commit;
    logic                   aw_in_range;
    logic                   ar_in_range;
    logic [IDX_WIDTH-1:0]   ar_idx;
    logic [NUM_REGS-1:0]    wr_sel;
    logic [DATA_WIDTH-1:0]  rd_value;
    logic                   unused_bits;

    // Word-index low bits and hw_in slices of RW registers are intentionally ignored.
    assign unused_bits = ^{AWADDR[ALSB-1:0], ARADDR[ALSB-1:0], hw_in};

    // Ready outputs are forced low while reset is asserted.
    assign AWREADY = !aw_held_q && !ARESET;
    assign WREADY  = !w_held_q && !ARESET;
    assign ARREADY = !rvalid_q && !ARESET;

    assign aw_hs  = AWVALID && AWREADY;
    assign w_hs   = WVALID && WREADY;
    assign ar_hs  = ARVALID && ARREADY;
    assign commit = aw_held_q && w_held_q && !bvalid_q;

    assign ar_idx      = ARADDR[ADDR_WIDTH-1:ALSB];
    assign aw_in_range = {1'b0, aw_idx_q} < REG_COUNT;
    assign ar_in_range = {1'b0, ar_idx} < REG_COUNT;

    assign BVALID   = bvalid_q;
    assign BRESP    = bresp_q;
    assign RVALID   = rvalid_q;
    assign RDATA    = rdata_q;
    assign RRESP    = rresp_q;
    assign wr_pulse = wr_pulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_hw_out
        assign hw_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    // One-hot select of the register being committed; out-of-range indices match nothing.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && (aw_idx_q == IDX_WIDTH'(i))) begin
                wr_sel[i] = 1'b1;
            end
        end
    end

    // Read mux: RO registers come from hw_in, out-of-range reads return zero.
    always_comb begin
        rd_value = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_WIDTH'(i)) begin
                rd_value = RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
            end
        end
    end

    // Write path: independent AW/W holds, commit when both held and no response pending.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= wr_sel;
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= aw_in_range ? RESP_OKAY : RESP_OOR;
            end else if (bvalid_q && BREADY) begin
                bvalid_q <= 1'b0;
            end
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                aw_idx_q  <= AWADDR[ADDR_WIDTH-1:ALSB];
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
        end
    end

    // Register storage: byte-strobed update of RW registers on commit.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i] && !RO_MASK[i]) begin
                    for (int b = 0; b < STRB_WIDTH; b++) begin
                        if (w_strb_q[b]) begin
                            regs_q[i][8*b +: 8] <= w_data_q[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read path: register data and response on AR handshake, hold until R handshake.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_value;
            rresp_q  <= ar_in_range ? RESP_OKAY : RESP_OOR;
        end else if (rvalid_q && RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Self-checking bench for axi_lite_regbank against an array-based reference model.
module tb_axi_lite_regbank;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam logic [NR-1:0] RO = 16'h0024;
`ifdef AXIL_REGBANK_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic              AWVALID = 1'b0, AWREADY;
    logic [AW-1:0]     AWADDR = '0;
    logic              WVALID = 1'b0, WREADY;
    logic [DW-1:0]     WDATA = '0;
    logic [DW/8-1:0]   WSTRB = '0;
    logic              BVALID, BREADY = 1'b0;
    logic [1:0]        BRESP;
    logic              ARVALID = 1'b0, ARREADY;
    logic [AW-1:0]     ARADDR = '0;
    logic              RVALID, RREADY = 1'b0;
    logic [DW-1:0]     RDATA;
    logic [1:0]        RRESP;
    logic [NR*DW-1:0]  hw_out;
    logic [NR*DW-1:0]  hw_in = '0;
    logic [NR-1:0]     wr_pulse;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] model [NR];
    logic [NR-1:0] ro_mask = RO;

    always #5 ACLK = ~ACLK;

    axi_lite_regbank #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .RO_MASK    (RO)
    ) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .AWADDR   (AWADDR),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .BRESP    (BRESP),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .ARADDR   (ARADDR),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .hw_out   (hw_out),
        .hw_in    (hw_in),
        .wr_pulse (wr_pulse)
    );

    // Reference model: what a read of word index idx should return.
    function automatic logic [DW-1:0] exp_read(input int idx);
        if (idx >= NR) return '0;
        if (ro_mask[idx]) return hw_in[idx*DW +: DW];
        return model[idx];
    endfunction

    function automatic logic [1:0] exp_resp(input int idx);
        return (idx < NR) ? 2'b00 : OOR_RESP;
    endfunction

    function automatic logic [NR-1:0] exp_pulse(input int idx);
        logic [NR-1:0] one = 1;
        return (idx < NR) ? (one << idx) : '0;
    endfunction

    task automatic model_write(input int idx, input logic [DW-1:0] data, input logic [3:0] strb);
        logic [DW-1:0] mask;
        if (idx >= NR || ro_mask[idx]) return;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        model[idx] = (model[idx] & ~mask) | (data & mask);
    endtask

    // Full write transaction; returns response and wr_pulse in the response cycle and after it.
    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output logic [NR-1:0] pulse, output logic [NR-1:0] pulse_after);
        bit aw_done, w_done, aw_hs, w_hs, got;
        int n;
        resp = 2'bxx; pulse = 'x; pulse_after = 'x;
        @(negedge ACLK);
        AWVALID = 1'b1; AWADDR = addr; WVALID = 1'b1; WDATA = data; WSTRB = strb;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            @(negedge ACLK);
            if (aw_hs) begin AWVALID = 1'b0; aw_done = 1; end
            if (w_hs)  begin WVALID = 1'b0;  w_done = 1;  end
            n++;
        end
        if (!(aw_done && w_done)) begin
            n_vec++; n_err++;
            $display("FAIL write_accept_timeout: addr %h not accepted, expected accept within 20 cycles", addr);
            AWVALID = 1'b0; WVALID = 1'b0;
            return;
        end
        BREADY = 1'b1; got = 0; n = 0;
        while (!got && n < 20) begin
            if (BVALID) begin resp = BRESP; pulse = wr_pulse; got = 1; end
            @(negedge ACLK);
            n++;
        end
        BREADY = 1'b0;
        pulse_after = wr_pulse;
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL write_resp_timeout: no BVALID, expected BVALID within 20 cycles");
        end
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                            output logic [1:0] resp);
        bit done, got;
        int n;
        data = 'x; resp = 2'bxx;
        @(negedge ACLK);
        ARVALID = 1'b1; ARADDR = addr; done = 0; n = 0;
        while (!done && n < 20) begin
            done = ARREADY;
            @(negedge ACLK);
            n++;
        end
        ARVALID = 1'b0;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL read_accept_timeout: addr %h not accepted, expected accept within 20 cycles", addr);
            return;
        end
        RREADY = 1'b1; got = 0; n = 0;
        while (!got && n < 20) begin
            if (RVALID) begin data = RDATA; resp = RRESP; got = 1; end
            @(negedge ACLK);
            n++;
        end
        RREADY = 1'b0;
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL read_data_timeout: no RVALID, expected RVALID within 20 cycles");
        end
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        for (int i = 0; i < NR; i++) model[i] = '0;
        repeat (3) @(negedge ACLK);
        n_vec++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
            n_err++; $display("FAIL rst_ready: got %b expected 000", {AWREADY, WREADY, ARREADY});
        end
        n_vec++;
        if ({BVALID, RVALID, BRESP, RRESP} !== 6'b0 || RDATA !== '0) begin
            n_err++; $display("FAIL rst_resp: got bv %b rv %b br %b rr %b rd %h expected all 0",
                              BVALID, RVALID, BRESP, RRESP, RDATA);
        end
        n_vec++;
        if (hw_out !== '0 || wr_pulse !== '0) begin
            n_err++; $display("FAIL rst_hw: got hw_out %h wr_pulse %h expected 0", hw_out, wr_pulse);
        end
        ARESET = 1'b0;
        @(negedge ACLK);
        n_vec++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            n_err++; $display("FAIL rst_release_ready: got %b expected 111", {AWREADY, WREADY, ARREADY});
        end
    endtask

    task automatic test_basic();
        logic [1:0] resp, rresp;
        logic [NR-1:0] p, pa;
        logic [DW-1:0] d;
        axi_write(12'h010, 32'hDEADBEEF, 4'hF, resp, p, pa);
        model_write(4, 32'hDEADBEEF, 4'hF);
        n_vec++;
        if (resp !== 2'b00) begin n_err++; $display("FAIL basic_bresp: got %b expected 00", resp); end
        n_vec++;
        if (p !== 16'h0010) begin n_err++; $display("FAIL basic_pulse: got %h expected 0010", p); end
        n_vec++;
        if (pa !== 16'h0000) begin n_err++; $display("FAIL basic_pulse_clear: got %h expected 0000", pa); end
        n_vec++;
        if (hw_out[4*DW +: DW] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL basic_hw_out: got %h expected deadbeef", hw_out[4*DW +: DW]);
        end
        axi_read(12'h010, d, rresp);
        n_vec++;
        if (d !== 32'hDEADBEEF || rresp !== 2'b00) begin
            n_err++; $display("FAIL basic_read: got %h/%b expected deadbeef/00", d, rresp);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp, rresp;
        logic [NR-1:0] p, pa;
        logic [DW-1:0] d;
        axi_write(12'h010, 32'h11223344, 4'h5, resp, p, pa);
        model_write(4, 32'h11223344, 4'h5);
        axi_read(12'h010, d, rresp);
        n_vec++;
        if (d !== 32'hDE22BE44) begin n_err++; $display("FAIL strobe_read: got %h expected de22be44", d); end
        axi_write(12'h010, 32'h0BAD0BAD, 4'h0, resp, p, pa);
        axi_read(12'h010, d, rresp);
        n_vec++;
        if (d !== 32'hDE22BE44 || resp !== 2'b00) begin
            n_err++; $display("FAIL strobe_zero: got %h/%b expected de22be44/00", d, resp);
        end
    endtask

    task automatic test_ro();
        logic [1:0] resp, rresp;
        logic [NR-1:0] p, pa;
        logic [DW-1:0] d;
        hw_in[2*DW +: DW] = 32'hCAFEF00D;
        axi_write(12'h008, 32'hFFFFFFFF, 4'hF, resp, p, pa);
        n_vec++;
        if (resp !== 2'b00 || p !== 16'h0004) begin
            n_err++; $display("FAIL ro_write: got resp %b pulse %h expected 00/0004", resp, p);
        end
        axi_read(12'h008, d, rresp);
        n_vec++;
        if (d !== 32'hCAFEF00D || rresp !== 2'b00) begin
            n_err++; $display("FAIL ro_read: got %h/%b expected cafef00d/00", d, rresp);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp, rresp;
        logic [NR-1:0] p, pa;
        logic [DW-1:0] d;
        axi_read(12'h040, d, rresp);
        n_vec++;
        if (d !== '0 || rresp !== OOR_RESP) begin
            n_err++; $display("FAIL oor_read: got %h/%b expected 0/%b", d, rresp, OOR_RESP);
        end
        axi_write(12'h040, $urandom, 4'hF, resp, p, pa);
        n_vec++;
        if (resp !== OOR_RESP || p !== '0) begin
            n_err++; $display("FAIL oor_write: got resp %b pulse %h expected %b/0000", resp, p, OOR_RESP);
        end
        for (int i = 0; i < NR; i++) begin
            axi_read(AW'(i * 4), d, rresp);
            n_vec++;
            if (d !== exp_read(i)) begin
                n_err++; $display("FAIL oor_storage[%0d]: got %h expected %h", i, d, exp_read(i));
            end
        end
    endtask

    // AW alone, W three cycles later, response held back four cycles.
    task automatic test_stall();
        logic [DW-1:0] data = $urandom;
        logic [1:0] resp0;
        @(negedge ACLK);
        AWVALID = 1'b1; AWADDR = 12'h01C;
        @(negedge ACLK);
        AWVALID = 1'b0;
        n_vec++;
        if ({AWREADY, WREADY, BVALID} !== 3'b010) begin
            n_err++; $display("FAIL stall_aw_held: got awr/wr/bv %b expected 010", {AWREADY, WREADY, BVALID});
        end
        repeat (2) @(negedge ACLK);
        WVALID = 1'b1; WDATA = data; WSTRB = 4'hF;
        @(negedge ACLK);
        WVALID = 1'b0;
        n_vec++;
        if ({WREADY, BVALID} !== 2'b00) begin
            n_err++; $display("FAIL stall_w_held: got wr/bv %b expected 00", {WREADY, BVALID});
        end
        @(negedge ACLK);
        model_write(7, data, 4'hF);
        n_vec++;
        if (BVALID !== 1'b1 || BRESP !== 2'b00 || wr_pulse !== 16'h0080) begin
            n_err++; $display("FAIL stall_commit: got bv %b br %b pulse %h expected 1/00/0080",
                              BVALID, BRESP, wr_pulse);
        end
        resp0 = BRESP;
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            n_vec++;
            if (BVALID !== 1'b1 || BRESP !== resp0) begin
                n_err++; $display("FAIL stall_b_hold[%0d]: got bv %b br %b expected 1/%b", k, BVALID, BRESP, resp0);
            end
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        n_vec++;
        if (BVALID !== 1'b0 || hw_out[7*DW +: DW] !== model[7]) begin
            n_err++; $display("FAIL stall_done: got bv %b reg7 %h expected 0/%h", BVALID, hw_out[7*DW +: DW], model[7]);
        end
    endtask

    // Commit and AR to the same register on the same edge return the old value.
    task automatic test_same_edge();
        logic [DW-1:0] old_val = exp_read(9);
        logic [DW-1:0] new_val = $urandom;
        logic [DW-1:0] d;
        logic [1:0] rresp;
        @(negedge ACLK);
        AWVALID = 1'b1; AWADDR = 12'h024; WVALID = 1'b1; WDATA = new_val; WSTRB = 4'hF;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        ARVALID = 1'b1; ARADDR = 12'h024;
        @(negedge ACLK);
        ARVALID = 1'b0;
        n_vec++;
        if (RVALID !== 1'b1 || BVALID !== 1'b1 || RDATA !== old_val) begin
            n_err++; $display("FAIL same_edge: got rv %b bv %b rdata %h expected 1/1/%h", RVALID, BVALID, RDATA, old_val);
        end
        model_write(9, new_val, 4'hF);
        RREADY = 1'b1; BREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0; BREADY = 1'b0;
        axi_read(12'h024, d, rresp);
        n_vec++;
        if (d !== model[9]) begin n_err++; $display("FAIL same_edge_after: got %h expected %h", d, model[9]); end
    endtask

    task automatic test_random();
        logic [1:0] resp;
        logic [NR-1:0] p, pa;
        logic [DW-1:0] d, data;
        logic [3:0] strb;
        logic [AW-1:0] addr;
        int idx;
        for (int it = 0; it < 60; it++) begin
            idx  = $urandom_range(0, 19);
            addr = AW'(idx * 4 + int'($urandom_range(0, 3)));
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            if (idx < NR && ro_mask[idx] && ($urandom_range(0, 1) == 1)) hw_in[idx*DW +: DW] = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                axi_write(addr, data, strb, resp, p, pa);
                model_write(idx, data, strb);
                n_vec++;
                if (resp !== exp_resp(idx) || p !== exp_pulse(idx)) begin
                    n_err++; $display("FAIL rand_write[%0d]: idx %0d got resp %b pulse %h expected %b/%h",
                                      it, idx, resp, p, exp_resp(idx), exp_pulse(idx));
                end
            end else begin
                axi_read(addr, d, resp);
                n_vec++;
                if (d !== exp_read(idx) || resp !== exp_resp(idx)) begin
                    n_err++; $display("FAIL rand_read[%0d]: idx %0d got %h/%b expected %h/%b",
                                      it, idx, d, resp, exp_read(idx), exp_resp(idx));
                end
            end
        end
    endtask

    // Reset with AW held and R pending: everything discarded, storage cleared.
    task automatic test_reset_mid();
        logic [DW-1:0] d;
        logic [1:0] rresp;
        hw_in = '0;
        @(negedge ACLK);
        AWVALID = 1'b1; AWADDR = 12'h000; ARVALID = 1'b1; ARADDR = 12'h010;
        @(negedge ACLK);
        AWVALID = 1'b0; ARVALID = 1'b0;
        n_vec++;
        if (RVALID !== 1'b1 || AWREADY !== 1'b0) begin
            n_err++; $display("FAIL mid_setup: got rv %b awr %b expected 1/0", RVALID, AWREADY);
        end
        ARESET = 1'b1;
        @(negedge ACLK);
        n_vec++;
        if ({BVALID, RVALID, BRESP, RRESP, AWREADY, WREADY, ARREADY} !== 9'b0 || RDATA !== '0 ||
            wr_pulse !== '0 || hw_out !== '0) begin
            n_err++; $display("FAIL mid_reset: got bv %b rv %b rd %h rdy %b hw_out %h expected all 0",
                              BVALID, RVALID, RDATA, {AWREADY, WREADY, ARREADY}, hw_out);
        end
        ARESET = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        @(negedge ACLK);
        WVALID = 1'b1; WDATA = 32'hFFFFFFFF; WSTRB = 4'hF;
        @(negedge ACLK);
        WVALID = 1'b0;
        repeat (2) @(negedge ACLK);
        n_vec++;
        if (BVALID !== 1'b0) begin n_err++; $display("FAIL mid_no_commit: got bv %b expected 0", BVALID); end
        // Pair the held W with a write to reg 3 so the bank is left idle.
        AWVALID = 1'b1; AWADDR = 12'h00C;
        @(negedge ACLK);
        AWVALID = 1'b0;
        model_write(3, 32'hFFFFFFFF, 4'hF);
        BREADY = 1'b1;
        repeat (2) @(negedge ACLK);
        BREADY = 1'b0;
        for (int i = 0; i < NR; i++) begin
            axi_read(AW'(i * 4), d, rresp);
            n_vec++;
            if (d !== exp_read(i)) begin
                n_err++; $display("FAIL mid_readback[%0d]: got %h expected %h", i, d, exp_read(i));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) hw_in[i*DW +: DW] = $urandom;
        test_reset();
        test_basic();
        test_strobe();
        test_ro();
        test_out_of_range();
        test_stall();
        test_same_edge();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
